sram_frame_arbiter: RTL and testbench



---
 rtl/sram_frame_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_frame_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: shares one async SRAM between CCD FIFO pixel writes and homography reads.
// Define SRAM_PINGPONG_EN for a second frame buffer with write/read bank swapping.
module sram_frame_arbiter #(
  parameter int FRAME_WIDTH = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COORD_W = 10,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 2,
  parameter int MAX_RD_RUN = 4
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iFIFO_ReadEmpty,
  input  logic [2*COORD_W+DATA_W-1:0]  iFIFO_Q,
  output logic                         oFIFO_ReadRequest,
  input  logic                         iHGRequest,
  input  logic [COORD_W-1:0]           iHGX,
  input  logic [COORD_W-1:0]           iHGY,
  output logic                         oHGBusy,
  output logic                         oHGValid,
  output logic [DATA_W-1:0]            oHGData,
  output logic [15:0]                  oDropCount,
  output logic [ADDR_W-1:0]            oSRAM_ADDR,
  output logic                         oSRAM_WE_N,
  output logic                         oSRAM_OE_N,
  inout  wire  [DATA_W-1:0]            ioSRAM_DQ
);
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  localparam int XW = COORD_W + 1;
  localparam logic [XW-1:0] X_LIM = XW'(FRAME_WIDTH);
  localparam logic [XW-1:0] Y_LIM = XW'(FRAME_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE = ADDR_W'(FRAME_WIDTH);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_DONE} state_t;

  state_t state, nextState;
  logic rdPend, accept, grantRd, grantWr, rdLast, rdIn, wrIn;
  logic [COORD_W-1:0] rdX, rdY, wrX, wrY, fifoX, fifoY;
  logic [DATA_W-1:0] wrPix, fifoPix;
  logic [2:0] latCnt;
  logic [RUN_W-1:0] runCnt;
  logic [ADDR_W-1:0] rdBase, wrBase;

  function automatic logic inFrame(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  endfunction

  function automatic logic [ADDR_W-1:0] pixAddr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * LINE + ADDR_W'(x);
  endfunction

`ifdef SRAM_PINGPONG_EN
  localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_HEIGHT - 1);
  logic wrBank, rdBank;
  // a read keeps the bank chosen when it was accepted, even across a frame swap
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      wrBank <= 1'b0;
      rdBank <= 1'b0;
    end else begin
      if (accept) rdBank <= ~wrBank;
      if (state == WRITE && wrX == X_LAST && wrY == Y_LAST) wrBank <= ~wrBank;
    end
  assign rdBase = rdBank ? BANK_OFS : '0;
  assign wrBase = wrBank ? BANK_OFS : '0;
`else
  assign rdBase = '0;
  assign wrBase = '0;
`endif

  assign {fifoX, fifoY, fifoPix} = iFIFO_Q;
  assign rdIn = inFrame(rdX, rdY);
  assign wrIn = inFrame(wrX, wrY);
  assign oHGBusy = rdPend && state != READ_DONE;
  assign accept = iHGRequest && !oHGBusy;
  assign grantRd = state == IDLE && rdPend && (runCnt < RUN_MAX || iFIFO_ReadEmpty);
  // iRST gating keeps the pop strobe quiet while reset holds the FSM in IDLE
  assign grantWr = iRST && state == IDLE && !grantRd && !iFIFO_ReadEmpty;
  assign rdLast = state == READ && (!rdIn || latCnt == LAT_LAST);
  assign oFIFO_ReadRequest = grantWr;
  assign oHGValid = state == READ_DONE;
  assign oSRAM_WE_N = !(state == WRITE && wrIn);
  assign oSRAM_OE_N = !(state == READ && rdIn);
  assign ioSRAM_DQ = oSRAM_WE_N ? 'z : wrPix;

  always_comb
    nextState = grantRd ? READ :
                grantWr ? WRITE :
                (state == WRITE || state == READ_DONE) ? IDLE :
                rdLast ? READ_DONE : state;

  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) state <= IDLE;
    else state <= nextState;

  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      rdPend <= 1'b0;
      rdX <= '0;
      rdY <= '0;
      wrX <= '0;
      wrY <= '0;
      wrPix <= '0;
      latCnt <= '0;
      runCnt <= '0;
      oHGData <= '0;
      oDropCount <= '0;
      oSRAM_ADDR <= '0;
    end else begin
      if (accept) begin
        rdPend <= 1'b1;
        rdX <= iHGX;
        rdY <= iHGY;
      end else if (state == READ_DONE) rdPend <= 1'b0;
      if (grantWr) begin
        {wrX, wrY, wrPix} <= {fifoX, fifoY, fifoPix};
        oSRAM_ADDR <= wrBase + pixAddr(fifoX, fifoY);
      end
      // reads taken while no write waits do not count towards the starvation limit
      if (grantRd) begin
        oSRAM_ADDR <= rdBase + pixAddr(rdX, rdY);
        runCnt <= (!iFIFO_ReadEmpty && runCnt < RUN_MAX) ? runCnt + 1'b1 : runCnt;
      end
      if (state == WRITE) begin
        runCnt <= '0;
        if (!wrIn && oDropCount != 16'hFFFF) oDropCount <= oDropCount + 16'd1;
      end
      latCnt <= state == READ ? latCnt + 3'd1 : 3'd0;
      if (rdLast) oHGData <= rdIn ? ioSRAM_DQ : '0;
    end
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// tb_sram_frame_arbiter: directed and randomized checks of sram_frame_arbiter against a FIFO/SRAM/pixel model.
module tb_sram_frame_arbiter;
  localparam int FW = 640, FH = 480;

  logic iCLK = 1'b0, iRST = 1'b1;
  logic iFIFO_ReadEmpty = 1'b1;
  logic [35:0] iFIFO_Q = '0;
  logic iHGRequest = 1'b0;
  logic [9:0] iHGX = '0, iHGY = '0;
  logic oFIFO_ReadRequest, oHGBusy, oHGValid, oSRAM_WE_N, oSRAM_OE_N;
  logic [15:0] oHGData, oDropCount;
  logic [19:0] oSRAM_ADDR;
  wire [15:0] ioSRAM_DQ;

  logic [15:0] mem [0:(1<<20)-1];
  logic [35:0] fifo [$];
  int expWrAddr [$];
  logic [15:0] expWrData [$];
  logic [15:0] expRd [$];
  int total = 0, bad = 0, cyc = 0, expDrop = 0, bothLow = 0;
  int popCnt, weCnt, oeCnt, validCnt, validCyc, sincePop, popsSeen, lastWeAddr, c0;
  logic gapCheck = 1'b0, lastOe = 1'b0;
  logic [15:0] lastData, lastWeData, held;

  sram_frame_arbiter dut (
    .iCLK(iCLK), .iRST(iRST), .iFIFO_ReadEmpty(iFIFO_ReadEmpty), .iFIFO_Q(iFIFO_Q),
    .oFIFO_ReadRequest(oFIFO_ReadRequest), .iHGRequest(iHGRequest), .iHGX(iHGX), .iHGY(iHGY),
    .oHGBusy(oHGBusy), .oHGValid(oHGValid), .oHGData(oHGData), .oDropCount(oDropCount),
    .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N), .ioSRAM_DQ(ioSRAM_DQ)
  );

  assign ioSRAM_DQ = oSRAM_OE_N ? 16'hzzzz : mem[oSRAM_ADDR];
  always #5 iCLK = ~iCLK;

  function automatic logic [15:0] pat(int a);
    return 16'((a * 37) ^ 16'h5A5A);
  endfunction

  function automatic logic inFrame(int x, int y);
    return x < FW && y < FH;
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    popCnt = 0; weCnt = 0; oeCnt = 0; validCnt = 0; validCyc = -1; sincePop = 0; popsSeen = 0;
  endtask

  task automatic syncFifo();
    iFIFO_ReadEmpty = fifo.size() == 0;
    iFIFO_Q = fifo.size() > 0 ? fifo[0] : '0;
  endtask

  task automatic push(int x, int y, logic [15:0] p);
    fifo.push_back({10'(x), 10'(y), p});
    syncFifo();
  endtask

  task automatic step();
    logic popNow, weNow;
    logic [19:0] a;
    logic [15:0] d;
    logic [35:0] w;
    int x, y;
    @(negedge iCLK);
    popNow = oFIFO_ReadRequest;
    weNow = !oSRAM_WE_N;
    a = oSRAM_ADDR;
    d = ioSRAM_DQ;
    lastOe = !oSRAM_OE_N;
    if (lastOe) oeCnt++;
    if (weNow && lastOe) bothLow++;
    if (weNow) begin
      weCnt++;
      lastWeAddr = int'(a);
      lastWeData = d;
      chk("wr_expected", expWrAddr.size() > 0, 1);
      if (expWrAddr.size() > 0) begin
        chk("wr_addr", a, expWrAddr.pop_front());
        chk("wr_data", d, expWrData.pop_front());
      end
    end
    if (oHGValid) begin
      validCnt++;
      validCyc = cyc;
      sincePop++;
      lastData = oHGData;
      chk("rd_expected", expRd.size() > 0, 1);
      if (expRd.size() > 0) chk("rd_data", oHGData, expRd.pop_front());
    end
    if (iHGRequest && !oHGBusy)
      expRd.push_back(inFrame(int'(iHGX), int'(iHGY)) ? mem[int'(iHGY) * FW + int'(iHGX)] : 16'h0);
    if (popNow) begin
      popCnt++;
      if (gapCheck) chk(popsSeen == 0 ? "gap_first" : "gap", sincePop, popsSeen == 0 ? 5 : 4);
      popsSeen++;
      sincePop = 0;
    end
    @(posedge iCLK);
    #1;
    cyc++;
    if (popNow) begin
      chk("pop_nonempty", fifo.size() > 0, 1);
      if (fifo.size() > 0) begin
        w = fifo.pop_front();
        x = int'(w[35:26]);
        y = int'(w[25:16]);
        if (inFrame(x, y)) begin
          expWrAddr.push_back(y * FW + x);
          expWrData.push_back(w[15:0]);
        end else if (expDrop < 65535) expDrop++;
        syncFifo();
      end
    end
    if (weNow) mem[a] = d;
  endtask

  initial begin
    for (int a = 0; a < (1 << 20); a++) mem[a] = pat(a);
    clr();
    #1 iRST = 1'b0;
    push(3, 2, 16'hABCD);
    #2;
    chk("rst_pop", oFIFO_ReadRequest, 0);
    chk("rst_busy", oHGBusy, 0);
    chk("rst_valid", oHGValid, 0);
    chk("rst_data", oHGData, 0);
    chk("rst_drop", oDropCount, 0);
    chk("rst_addr", oSRAM_ADDR, 0);
    chk("rst_we", oSRAM_WE_N, 1);
    chk("rst_oe", oSRAM_OE_N, 1);
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_pop_held", oFIFO_ReadRequest, 0);
    iRST = 1'b1;
    repeat (4) step();
    chk("t1_pops", popCnt, 1);
    chk("t1_we_cycles", weCnt, 1);
    chk("t1_addr", lastWeAddr, 1283);
    chk("t1_dq", lastWeData, 16'hABCD);

    clr();
    mem[645] = 16'h1234;
    iHGX = 10'd5; iHGY = 10'd1; iHGRequest = 1'b1;
    c0 = cyc;
    step();
    iHGRequest = 1'b0;
    chk("t2_busy_rise", oHGBusy, 1);
    for (int i = 0; i < 20 && validCnt == 0; i++) step();
    repeat (2) step();
    chk("t2_latency", validCyc - c0, 4);
    chk("t2_data", lastData, 16'h1234);
    chk("t2_oe_cycles", oeCnt, 2);

    clr();
    iHGRequest = 1'b1;
    for (int i = 0; i < 200 && validCnt < 3; i++) begin
      iHGX = 10'($urandom_range(FW - 1, 0)); iHGY = 10'($urandom_range(199, 0));
      step();
    end
    chk("t3_empty_reads", validCnt, 3);
    for (int i = 0; i < 50 && !lastOe; i++) step();
    for (int i = 0; i < 24; i++)
      push(int'($urandom_range(1023, 0)), int'($urandom_range(FH - 1, 200)), 16'($urandom));
    sincePop = 0; popsSeen = 0; gapCheck = 1'b1;
    for (int i = 0; i < 3000 && (fifo.size() > 0 || expWrAddr.size() > 0); i++) begin
      iHGX = 10'($urandom_range(FW - 1, 0)); iHGY = 10'($urandom_range(199, 0));
      step();
    end
    gapCheck = 1'b0;
    iHGRequest = 1'b0;
    for (int i = 0; i < 50 && (oHGBusy || expRd.size() > 0); i++) step();
    step();
    chk("t3_pops", popsSeen, 24);
    chk("t3_rd_drain", expRd.size(), 0);
    chk("t3_drop", oDropCount, expDrop);

    clr();
    c0 = expDrop;
    push(640, 0, 16'h1111);
    push(0, 480, 16'h2222);
    repeat (10) step();
    chk("t4_pops", popCnt, 2);
    chk("t4_we_cycles", weCnt, 0);
    chk("t4_drop", oDropCount, c0 + 2);
    clr();
    iHGX = 10'd700; iHGY = 10'd0; iHGRequest = 1'b1;
    c0 = cyc;
    step();
    iHGRequest = 1'b0;
    for (int i = 0; i < 20 && validCnt == 0; i++) step();
    chk("t4_oob_latency", validCyc - c0, 3);
    chk("t4_oob_data", lastData, 0);
    chk("t4_oob_oe", oeCnt, 0);

    clr();
    iHGX = 10'd2; iHGY = 10'd3; iHGRequest = 1'b1;
    step();
    iHGX = 10'd4; iHGY = 10'd4;
    repeat (3) step();
    iHGRequest = 1'b0;
    repeat (12) step();
    held = mem[3 * FW + 2];
    chk("t5_one_valid", validCnt, 1);
    chk("t5_data", lastData, held);
    chk("t5_held", oHGData, held);

    clr();
    iHGX = 10'd1; iHGY = 10'd1; iHGRequest = 1'b1;
    step();
    iHGRequest = 1'b0;
    for (int i = 0; i < 20 && !lastOe; i++) step();
    chk("t6_in_read", lastOe, 1);
    iRST = 1'b0;
    #1;
    chk("t6_oe", oSRAM_OE_N, 1);
    chk("t6_we", oSRAM_WE_N, 1);
    chk("t6_valid", oHGValid, 0);
    chk("t6_busy", oHGBusy, 0);
    chk("t6_addr", oSRAM_ADDR, 0);
    expRd.delete();
    expDrop = 0;
    repeat (2) step();
    iRST = 1'b1;
    repeat (8) step();
    chk("t6_no_valid", validCnt, 0);
    chk("t6_drop", oDropCount, expDrop);

    chk("we_oe_overlap", bothLow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
